// File: rtl/inport_req_pkg.sv
// Shared switch definitions: logic levels, flit field positions and the
// input-port FSM state encoding used by every switch port.
package inport_req_pkg;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    // Head/tail sit above the payload; offsets are relative to DATAW
    localparam int HEAD_OFS = 1;
    localparam int TAIL_OFS = 0;
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 2;
    localparam int NPORTS   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        REL  = 2'd3
    } state_t;

endpackage

// File: rtl/inport_req_flit_fifo.sv
// Synchronous flit FIFO with registered pointers; a pushed flit becomes
// visible at dout one cycle later at the earliest.
module flit_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inport_req.sv
// Switch input port: buffers flits, requests the output port named by the
// head flit and forwards the packet to the crossbar while the grant holds.
module inport_req
    import inport_req_pkg::*;
#(
    parameter int DATAW = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW+1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    output logic             req0,
    output logic             req1,
    output logic             req2,
    output logic             req3,
    input  logic             ack0,
    input  logic             ack1,
    input  logic             ack2,
    input  logic             ack3,
    output logic [DATAW+1:0] odata,
    output logic             ovalid,
    output logic             err
);
    localparam int FW = DATAW + 2;

    state_t              state;
    state_t              state_next;
    logic [DEST_W-1:0]   dest;
    logic [DEST_W-1:0]   dest_next;
    logic [FW-1:0]       fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fwd;
    logic                drop;
    logic [NPORTS-1:0]   ack_vec;
    logic [NPORTS-1:0]   req_vec;
    logic                dest_ack;
    logic                front_head;
    logic                front_tail;

    assign ack_vec    = {ack3, ack2, ack1, ack0};
    assign dest_ack   = ack_vec[dest];
    assign front_head = fifo_dout[DATAW+HEAD_OFS];
    assign front_tail = fifo_dout[DATAW+TAIL_OFS];
    assign fifo_push  = ivalid & ~fifo_full;
    assign iready     = ~fifo_full;

    flit_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (idata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dest  <= '0;
        end else begin
            state <= state_next;
            dest  <= dest_next;
        end
    end

    // The head flit stays in the FIFO until SEND so it is forwarded with the packet
    always_comb begin
        state_next = state;
        dest_next  = dest;
        fifo_pop   = NEGATE;
        fwd        = NEGATE;
        drop       = NEGATE;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (front_head) begin
                        dest_next  = fifo_dout[DEST_LSB +: DEST_W];
                        state_next = REQ;
                    end else begin
                        fifo_pop = ASSERT;
                        drop     = ASSERT;
                    end
                end
            end
            REQ: begin
                if (dest_ack) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (dest_ack && !fifo_empty) begin
                    fifo_pop = ASSERT;
                    fwd      = ASSERT;
                    if (front_tail) begin
                        state_next = REL;
                    end
                end
            end
            REL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_vec = '0;
        if (state == REQ || state == SEND) begin
            req_vec[dest] = ASSERT;
        end
    end

    assign req0 = req_vec[0];
    assign req1 = req_vec[1];
    assign req2 = req_vec[2];
    assign req3 = req_vec[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid <= NEGATE;
            err    <= NEGATE;
            odata  <= '0;
        end else begin
            ovalid <= fwd;
            err    <= drop;
            if (fwd) begin
                odata <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_inport_req.sv
// Scoreboard bench for inport_req: a packet-level model predicts forwarded
// flits and discards; a registered-grant arbiter model drives the acks.
module tb_inport_req;
    localparam int DATAW = 16;
    localparam int DEPTH = 4;
    localparam int FW    = DATAW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] idata;
    logic          ivalid;
    logic          iready;
    logic          req0, req1, req2, req3;
    logic          ack0, ack1, ack2, ack3;
    logic [FW-1:0] odata;
    logic          ovalid;
    logic          err;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic [1:0]    dest;
    } exp_t;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    int         exp_err   = 0;
    int         err_seen  = 0;
    bit         model_in_pkt = 1'b0;
    logic [1:0] model_dest   = 2'd0;
    int         ack_mode  = 0;
    int         drop_n    = 0;
    bit         drop_on_ovalid = 1'b0;
    bit         mon_en    = 1'b0;
    logic [3:0] prev_req  = 4'd0;

    always #5 clk = ~clk;

    inport_req #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .req0   (req0),
        .req1   (req1),
        .req2   (req2),
        .req3   (req3),
        .ack0   (ack0),
        .ack1   (ack1),
        .ack2   (ack2),
        .ack3   (ack3),
        .odata  (odata),
        .ovalid (ovalid),
        .err    (err)
    );

    function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [DATAW-1:0] p);
        return {h, t, p};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Packet-level reference: body flits outside a packet are discarded,
    // everything from a head through its tail goes to the head's port.
    task automatic modelAccept(input logic [FW-1:0] f);
        if (!model_in_pkt) begin
            if (f[FW-1]) begin
                model_dest = f[1:0];
                exp_q.push_back({f, model_dest});
                model_in_pkt = !f[FW-2];
            end else begin
                exp_err++;
            end
        end else begin
            exp_q.push_back({f, model_dest});
            if (f[FW-2]) model_in_pkt = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the flit is accepted
    task automatic applyStimulus(input logic [FW-1:0] f);
        int budget;
        budget = 300;
        idata  = f;
        ivalid = 1'b1;
        while (!iready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: iready stayed 0, expected 1");
        end
        @(posedge clk);
        modelAccept(f);
        @(negedge clk);
        ivalid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 2000;
        while ((exp_q.size() != 0 || ovalid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Arbiter model: grant follows request one cycle later, optionally gated
    initial begin : arbiter
        logic [3:0] a;
        logic [3:0] arb_prev;
        arb_prev = 4'd0;
        {ack3, ack2, ack1, ack0} = 4'd0;
        forever begin
            @(negedge clk);
            if (drop_on_ovalid && ovalid) begin
                drop_on_ovalid = 1'b0;
                drop_n = 2;
            end
            a = arb_prev;
            if (ack_mode == 2) a = 4'd0;
            else if (ack_mode == 1 && $urandom_range(3) == 0) a = 4'd0;
            if (drop_n > 0) begin
                a = 4'd0;
                drop_n--;
            end
            {ack3, ack2, ack1, ack0} = a;
            arb_prev = {req3, req2, req1, req0};
        end
    end

    initial begin : monitor
        logic [3:0] r;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                r = {req3, req2, req1, req0};
                checkOutput("req_onehot", ($countones(r) <= 1) ? 32'd1 : 32'd0, 32'd1);
                if (ovalid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_flit: got 0x%0h, expected no output", odata);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("odata", odata, e.flit);
                        checkOutput("out_port", prev_req, 4'b0001 << e.dest);
                    end
                end
                if (err) err_seen++;
                prev_req = r;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic [5:0]  rv, ovv;
        logic [FW-1:0] od4;
        logic [3:0]  allreq4;
        int first, last, seen, r3low, cnt, cnt2;
        logic [2:0]  ov3;
        logic        r1after;
        int len;
        logic [1:0]  d;

        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_iready", iready, 1);
        checkOutput("reset_req", {req3, req2, req1, req0}, 0);
        checkOutput("reset_ovalid", ovalid, 0);
        checkOutput("reset_odata", odata, 0);
        checkOutput("reset_err", err, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single-flit latency
        $display("[TB] single flit to port 2");
        applyStimulus(mk(1'b1, 1'b1, 16'h0002));
        for (int k = 0; k < 6; k++) begin
            rv[k]  = req2;
            ovv[k] = ovalid;
            if (k == 4) begin
                od4 = odata;
                allreq4 = {req3, req2, req1, req0};
            end
            @(negedge clk);
        end
        checkOutput("req2_window", rv, 6'b001110);
        checkOutput("ovalid_window", ovv, 6'b010000);
        checkOutput("odata_t4", od4, 18'h30002);
        checkOutput("req_low_t4", allreq4, 0);
        waitDrain();

        // Three-flit packet, continuous grant
        $display("[TB] 3-flit packet to port 1");
        applyStimulus(mk(1'b1, 1'b0, 16'hA001));
        applyStimulus(mk(1'b0, 1'b0, 16'hB002));
        applyStimulus(mk(1'b0, 1'b1, 16'hC003));
        first = -1; ov3 = 3'b000; r1after = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (first < 0 && ovalid) first = k;
            if (first >= 0 && k - first < 3) ov3[k-first] = ovalid;
            if (first >= 0 && k == first + 2) r1after = req1;
            @(negedge clk);
        end
        checkOutput("pkt3_ovalid_run", ov3, 3'b111);
        checkOutput("pkt3_req1_drop", r1after, 0);
        waitDrain();

        // Grant lost for two cycles mid-packet
        $display("[TB] 4-flit packet to port 3 with grant gap");
        drop_on_ovalid = 1'b1;
        applyStimulus(mk(1'b1, 1'b0, 16'h1113));
        applyStimulus(mk(1'b0, 1'b0, 16'h2222));
        applyStimulus(mk(1'b0, 1'b0, 16'h3333));
        applyStimulus(mk(1'b0, 1'b1, 16'h4444));
        seen = 0; first = 0; last = 0; r3low = 0;
        for (int k = 0; k < 60 && seen < 4; k++) begin
            if (ovalid) begin
                seen++;
                if (seen == 1) first = k;
                if (seen == 4) last = k;
            end
            if (seen >= 1 && seen < 4 && !req3) r3low++;
            @(negedge clk);
        end
        checkOutput("gap_flits", seen, 4);
        checkOutput("gap_cycles", last - first + 1 - 4, 2);
        checkOutput("gap_req3_low", r3low, 0);
        waitDrain();

        // FIFO full with grant withheld
        $display("[TB] fill FIFO with grant withheld");
        ack_mode = 2;
        applyStimulus(mk(1'b1, 1'b0, 16'h0101));
        applyStimulus(mk(1'b0, 1'b0, 16'h0202));
        applyStimulus(mk(1'b0, 1'b0, 16'h0303));
        applyStimulus(mk(1'b0, 1'b0, 16'h0404));
        checkOutput("full_iready", iready, 0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (iready) cnt++;
        end
        checkOutput("full_held", cnt, 0);
        ack_mode = 0;
        applyStimulus(mk(1'b0, 1'b1, 16'h0505));
        waitDrain();

        // Stray body flit in IDLE
        $display("[TB] stray body flit");
        applyStimulus(mk(1'b0, 1'b0, 16'h5A5A));
        cnt = 0; cnt2 = 0;
        for (int k = 0; k < 6; k++) begin
            if (err) cnt++;
            if ({req3, req2, req1, req0} != 4'd0) cnt2++;
            @(negedge clk);
        end
        checkOutput("stray_err_pulses", cnt, 1);
        checkOutput("stray_req_cycles", cnt2, 0);
        waitDrain();

        // Reset in the middle of a packet
        $display("[TB] reset during SEND to port 0");
        applyStimulus(mk(1'b1, 1'b0, 16'h00F0));
        applyStimulus(mk(1'b0, 1'b0, 16'h00F1));
        applyStimulus(mk(1'b0, 1'b0, 16'h00F2));
        cnt = 0;
        while (!ovalid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("rst_pkt_started", ovalid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_in_pkt = 1'b0;
        @(negedge clk);
        checkOutput("rst_req0", req0, 0);
        checkOutput("rst_ovalid", ovalid, 0);
        checkOutput("rst_iready", iready, 1);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ovalid) cnt++;
        end
        checkOutput("rst_no_leftover", cnt, 0);

        // Randomized packets with random grant gaps
        $display("[TB] random traffic");
        ack_mode = 1;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(5) == 0) begin
                applyStimulus(mk(1'b0, 1'($urandom_range(1)), 16'($urandom())));
            end
            len = $urandom_range(1, 4);
            d = 2'($urandom_range(3));
            for (int i = 0; i < len; i++) begin
                applyStimulus(mk(i == 0, i == len - 1, {14'($urandom()), d}));
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end
        waitDrain();

        checkOutput("err_count", err_seen, exp_err);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inport_req.md
INPORT_REQ -- requirements
Module: inport_req

Interface
REQ-001 The block SHALL have parameter DATAW, default 16, flit payload width.
REQ-002 The block SHALL have parameter DEPTH, default 4, flit FIFO depth in flits (power of two).
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 idata  input  DATAW+2  incoming flit {head, tail, payload}; payload[1:0] of a head flit is destination port.
REQ-007 ivalid  input  1  idata valid this cycle.
REQ-008 iready  output  1  FIFO can accept a flit (not full).
REQ-009 req0..req3  output  1 each  request to output-port arbiter 0..3, at most one high.
REQ-010 ack0..ack3  input  1 each  grant from output-port arbiter 0..3, registered in the arbiter (one cycle after req).
REQ-011 odata  output  DATAW+2  flit forwarded to the crossbar.
REQ-012 ovalid  output  1  odata valid this cycle.
REQ-013 err  output  1  one-cycle pulse: non-head flit discarded in IDLE.

Function
REQ-014 The block SHALL push idata into the FIFO when ivalid && iready; iready = !full; no push while full.
REQ-015 The block SHALL NOT bypass: a flit pushed at cycle T is poppable at T+1 at the earliest.
REQ-016 The FSM SHALL have the states IDLE, REQ, SEND and REL.
REQ-017 IDLE: with the FIFO non-empty and the front flit's head=1, the block SHALL latch dest=payload[1:0] and go to REQ, without popping.
REQ-018 IDLE: with the FIFO non-empty and the front flit's head=0, the block SHALL pop it, pulse err, and stay in IDLE.
REQ-019 req[dest] SHALL be high exactly in REQ and SEND (decoded from state and latched dest); all req SHALL be low in IDLE and REL.
REQ-020 REQ: ack[dest]=1 SHALL move the FSM to SEND; otherwise it stays in REQ with req held; ack of any other port SHALL be ignored.
REQ-021 SEND: ack[dest]=1 with the FIFO non-empty SHALL pop one flit and register it to odata with ovalid=1 the next cycle.
REQ-022 SEND: popping a flit with tail=1 SHALL move the FSM to REL.
REQ-023 SEND: ack[dest]=0 (grant lost mid-packet) SHALL stall: no pop, ovalid=0 next cycle, req held, resume when ack returns.
REQ-024 SEND: an empty FIFO SHALL stall the same way, with req held.
REQ-025 REL: the block SHALL hold all req low for exactly one cycle, then go to IDLE, so the arbiter sees req drop; the stale ack during REL and the following cycle SHALL be ignored.
REQ-026 A single-flit packet (head=1, tail=1) SHALL go IDLE->REQ->SEND->REL.
REQ-027 Latency: with ack arriving as soon as possible, a head at the FIFO front in IDLE at T SHALL give req at T+1, ack at T+2, SEND at T+3, pop at T+3, and ovalid at T+4.
REQ-028 Throughput: SEND with continuous ack and data SHALL give one flit per cycle.
REQ-029 Simultaneous push and pop SHALL be allowed when not full; the count stays unchanged.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-031 On rst the block SHALL set state=IDLE, FIFO empty, iready=1, req0..3=0, ovalid=0, odata=0 and err=0.
REQ-032 rst asserted mid-packet SHALL abort the packet and discard FIFO contents; req SHALL be low in the cycle after rst.

Structure
REQ-033 ASSERT/NEGATE, the flit field positions (head, tail, dest bits) and the FSM state encoding SHALL live in the shared switch header sw.vh.
REQ-034 The FIFO SHALL be a sub-module flit_fifo (push, pop, din, dout, full, empty), reusable by other switch ports.
REQ-035 The FSM and req decode SHALL be in inport_req.

Verification
REQ-036 A single flit {1,1,0x0002} with ack2 returned one cycle after req2 SHALL give req2 at T+1..T+3 only, odata=0x30002 with ovalid at T+4, and all req low at T+4.
REQ-037 A 3-flit packet to port 1 with ack1 held SHALL give three consecutive ovalid cycles, then req1 low for at least one cycle.
REQ-038 ack3 dropping for 2 cycles after the 1st flit of a 4-flit packet SHALL give two ovalid=0 cycles, req3 held throughout, all 4 flits delivered in order, and no duplicate.
REQ-039 Pushing 5 flits back-to-back with ack withheld SHALL give iready=0 after the 4th, the 5th held off, and no loss after ack arrives.
REQ-040 A body flit {0,0,x} at the front in IDLE SHALL be popped with err=1 for one cycle, and no req.
REQ-041 rst during SEND of a packet to port 0 SHALL give req0=0, ovalid=0 and iready=1 next cycle, with no remaining flits forwarded.
